// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bundle between the decode front end and the registered immediate generator.
// The slave modport is the generator's view; the master modport is the driver's view.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned SEL_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [SEL_W-1:0] in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport slave (
    input  in_valid, in_inst, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport master (
    output in_valid, in_inst, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes I/S/B/U/J/Z immediates into an output
// register backed by a one-entry skid register so that in_ready is a flop output.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned SEL_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  imm_gen_pipe_if.slave    bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (SEL_W < 6) begin : g_bad_sel
    $error("imm_gen_pipe: SEL_W must be at least 6");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } beat_t;

  state_e state_q, state_d;
  beat_t  r0_q, r0_d;
  beat_t  r1_q, r1_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;

  logic [31:0]        inst;
  logic [SEL_W-1:0]   sel;
  logic signed [31:0] raw;
  logic [XLEN-1:0]    gen_imm;
  logic               sel_err;
  beat_t              beat_in;
  logic               accept;
  logic               drain;
  logic               unused_opcode;

  assign inst          = bus.in_inst;
  assign sel           = bus.in_sel;
  assign unused_opcode = ^inst[6:0];

  // Every signed format is built as a 32-bit value first, then widened by a signed cast.
  always_comb begin
    raw     = '0;
    gen_imm = '0;
    sel_err = !$onehot(sel);
    if (!sel_err) begin
      if (sel[0]) begin
        raw     = {{20{inst[31]}}, inst[31:20]};
        gen_imm = XLEN'(raw);
      end else if (sel[1]) begin
        raw     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        gen_imm = XLEN'(raw);
      end else if (sel[2]) begin
        raw     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        gen_imm = XLEN'(raw);
      end else if (sel[3]) begin
        raw     = {inst[31:12], 12'b0};
        gen_imm = XLEN'(raw);
      end else if (sel[4]) begin
        raw     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        gen_imm = XLEN'(raw);
      end else if (sel[5]) begin
        gen_imm = XLEN'(inst[19:15]);
      end
    end
    beat_in.imm = gen_imm;
    beat_in.tag = bus.in_tag;
    beat_in.err = sel_err;
  end

  always_comb begin
    accept  = bus.in_valid && in_ready_q && !flush;
    drain   = out_valid_q && bus.out_ready;
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          r0_d    = beat_in;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          r0_d = beat_in;
        end else if (accept) begin
          r1_d    = beat_in;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          r0_d    = r1_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops occupancy only; the stale R0 payload stays visible on out_imm/out_tag.
    if (flush) begin
      state_d = EMPTY;
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= EMPTY;
      r0_q        <= '0;
      r1_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = r0_q.imm;
  assign bus.out_tag   = r0_q.tag;
  assign bus.out_err   = r0_q.err;

endmodule
